fft_output_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_reorder_bank.sv | 33 +++
 rtl/fft_output_reorder.sv | 191 +++++++++++++++++++
 tb/tb_fft_output_reorder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, bit-reversal helper and read-FSM encoding for the
// 32-point, 4-lane FFT output path.
package fft_pkg;

  localparam int WORDSIZE   = 16;
  localparam int NUMSAMPLES = 32;
  localparam int LANES      = 4;
  localparam int BEATS      = 8;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] idx);
    return {idx[0], idx[1], idx[2], idx[3], idx[4]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame-sized register bank: a 4-word write port addressed by beat and
// four independent combinational read ports.
module fft_reorder_bank #(
  parameter int WORDSIZE = 16,
  parameter int ADDRSIZE = 3
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDRSIZE-1:0]           wr_beat,
  input  logic [4*WORDSIZE-1:0]         wr_data,
  input  logic [4*(ADDRSIZE+2)-1:0]     rd_addr,
  output logic [4*WORDSIZE-1:0]         rd_data
);
  import fft_pkg::LANES;

  localparam int AW = ADDRSIZE + 2;

  logic [WORDSIZE-1:0] mem [2**AW];

  // Contents are deliberately not reset; a frame is only read once it is complete.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        mem[{wr_beat, l[1:0]}] <= wr_data[l*WORDSIZE +: WORDSIZE];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_rd
    assign rd_data[g*WORDSIZE +: WORDSIZE] = mem[rd_addr[g*AW +: AW]];
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: collects bit-reversed frames from the last FFT
// stage and streams them out in natural order over ready/valid.
module fft_output_reorder #(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int ADDRSIZE   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WORDSIZE-1:0] in0,
  input  logic [WORDSIZE-1:0] in1,
  input  logic [WORDSIZE-1:0] in2,
  input  logic [WORDSIZE-1:0] in3,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [WORDSIZE-1:0] out0,
  output logic [WORDSIZE-1:0] out1,
  output logic [WORDSIZE-1:0] out2,
  output logic [WORDSIZE-1:0] out3,
  output logic                out_last,
  output logic                overflow
);
  import fft_pkg::LANES;
  import fft_pkg::bitrev5;
  import fft_pkg::rd_state_t;
  import fft_pkg::RD_IDLE;
  import fft_pkg::RD_STREAM;

  localparam int AW = ADDRSIZE + 2;
  localparam int FRAME_BEATS = NUMSAMPLES / LANES;
  localparam logic [ADDRSIZE-1:0] LAST_BEAT = ADDRSIZE'(FRAME_BEATS - 1);

  rd_state_t state, state_nxt;
  logic                  wsel, rsel, rsel_nxt;
  logic [ADDRSIZE-1:0]   wcnt, rcnt, rcnt_nxt, rd_beat;
  logic [1:0]            full;
  logic                  rd_done, wr_ok, wr_last;
  logic                  load, rd_bank, valid_nxt, last_nxt;
  logic [4*WORDSIZE-1:0] wr_data, rd_data_a, rd_data_b, rd_data;
  logic [4*AW-1:0]       rd_addr;

  assign wr_data = {in3, in2, in1, in0};
  assign rd_done = (state == RD_STREAM) && out_ready && (rcnt == LAST_BEAT);
  // A bank finishing its last read beat this cycle can already take the next
  // frame's first beat, so sustained full-rate input never overflows.
  assign wr_ok   = wr_en && (!full[wsel] || (rd_done && (rsel == wsel)));
  assign wr_last = wr_ok && (wcnt == LAST_BEAT);

  for (genvar g = 0; g < LANES; g++) begin : g_addr
    assign rd_addr[g*AW +: AW] = bitrev5({rd_beat, 2'(g)});
  end

  assign rd_data = rd_bank ? rd_data_b : rd_data_a;

  fft_reorder_bank #(.WORDSIZE(WORDSIZE), .ADDRSIZE(ADDRSIZE)) u_bank_a (
    .clk     (clk),
    .wr_en   (wr_ok && !wsel),
    .wr_beat (wcnt),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data_a)
  );

  fft_reorder_bank #(.WORDSIZE(WORDSIZE), .ADDRSIZE(ADDRSIZE)) u_bank_b (
    .clk     (clk),
    .wr_en   (wr_ok && wsel),
    .wr_beat (wcnt),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data_b)
  );

  // Write pointer, beat counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel     <= 1'b0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_last) begin
          wcnt <= '0;
          wsel <= ~wsel;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Bank ownership: the write side fills a flag, the read side drains it.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (rd_done) begin
        full[rsel] <= 1'b0;
      end
      if (wr_last) begin
        full[wsel] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rsel_nxt  = rsel;
    rcnt_nxt  = rcnt;
    rd_bank   = rsel;
    rd_beat   = rcnt;
    load      = 1'b0;
    valid_nxt = out_valid;
    last_nxt  = out_last;
    case (state)
      RD_IDLE: begin
        if (full[rsel]) begin
          state_nxt = RD_STREAM;
          rcnt_nxt  = '0;
          rd_beat   = '0;
          load      = 1'b1;
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
        end else begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
      end
      RD_STREAM: begin
        if (!out_ready) begin
          valid_nxt = 1'b1;
        end else if (rcnt == LAST_BEAT) begin
          rsel_nxt = ~rsel;
          rcnt_nxt = '0;
          last_nxt = 1'b0;
          if (full[~rsel]) begin
            rd_bank   = ~rsel;
            rd_beat   = '0;
            load      = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            state_nxt = RD_IDLE;
            valid_nxt = 1'b0;
          end
        end else begin
          rd_beat   = rcnt + 1'b1;
          rcnt_nxt  = rd_beat;
          load      = 1'b1;
          valid_nxt = 1'b1;
          last_nxt  = (rd_beat == LAST_BEAT);
        end
      end
      default: begin
        state_nxt = RD_IDLE;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  // Read FSM state and registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_IDLE;
      rsel      <= 1'b0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else begin
      state     <= state_nxt;
      rsel      <= rsel_nxt;
      rcnt      <= rcnt_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      if (load) begin
        out0 <= rd_data[0*WORDSIZE +: WORDSIZE];
        out1 <= rd_data[1*WORDSIZE +: WORDSIZE];
        out2 <= rd_data[2*WORDSIZE +: WORDSIZE];
        out3 <= rd_data[3*WORDSIZE +: WORDSIZE];
      end
    end
  end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Randomized and directed bench for fft_output_reorder against a frame-level
// reference model (whole frames, bit-reversal arithmetic, two-frame capacity).
module tb_fft_output_reorder;

  localparam int W = 16;
  typedef logic [32*W-1:0] frame_t;
  typedef struct {
    logic [4*W-1:0] data;
    logic           last;
    int             en;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst, wr_en, out_ready;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_valid, out_last, overflow;
  logic [W-1:0] out0, out1, out2, out3;

  always #5 clk = ~clk;

  fft_output_reorder #(.WORDSIZE(W), .NUMSAMPLES(32), .ADDRSIZE(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_ready(out_ready), .out_valid(out_valid),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_last(out_last), .overflow(overflow)
  );

  int     n_total = 0;
  int     n_bad = 0;
  frame_t exp_q[$];
  int     done_q[$];
  beat_t  log_q[$];
  frame_t part;
  int     pcnt, rd_b, edge_n, last_in_edge;
  logic   ovf_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < 5; i++) begin
      if (((x >> i) & 1) != 0) r += (16 >> i);
    end
    return r;
  endfunction

  // Model one clock edge: check what the DUT shows now, then apply the edge.
  task automatic model_edge();
    logic [4*W-1:0] obs, inw;
    logic exp_valid, xfer, last_xfer;
    frame_t f;
    obs = {out3, out2, out1, out0};
    inw = {in3, in2, in1, in0};
    exp_valid = (done_q.size() > 0) && (done_q[0] <= edge_n - 2);
    check_val("out_valid", 32'(out_valid), 32'(exp_valid));
    check_val("overflow", 32'(overflow), 32'(ovf_m));
    if (exp_valid && out_valid) begin
      f = exp_q[0];
      for (int l = 0; l < 4; l++) begin
        check_val($sformatf("beat%0d_lane%0d", rd_b, l), 32'(obs[W*l +: W]),
                  32'(f[W*brev(4*rd_b + l) +: W]));
      end
      check_val("out_last", 32'(out_last), 32'(rd_b == 7));
    end
    xfer = exp_valid && out_ready;
    last_xfer = xfer && (rd_b == 7);
    if (xfer) log_q.push_back('{obs, out_last, edge_n});
    if (last_xfer) begin
      void'(exp_q.pop_front());
      void'(done_q.pop_front());
      rd_b = 0;
    end else if (xfer) begin
      rd_b++;
    end
    if (wr_en) begin
      if (exp_q.size() >= 2) begin
        ovf_m = 1'b1;
      end else begin
        for (int l = 0; l < 4; l++) part[W*(4*pcnt + l) +: W] = inw[W*l +: W];
        pcnt++;
        if (pcnt == 8) begin
          exp_q.push_back(part);
          done_q.push_back(edge_n);
          pcnt = 0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic step(input logic w, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input logic [W-1:0] d3, input logic rdy);
    wr_en = w; in0 = d0; in1 = d1; in2 = d2; in3 = d3; out_ready = rdy;
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, '0, rdy);
  endtask

  // mode 0: contiguous, 1: wr_en pattern 1,0,1,1,0, 2: random gaps + random data.
  // rdy_mode 0/1: constant out_ready, 2: random out_ready.
  task automatic send_frame(input int base, input int mode, input int rdy_mode);
    logic [4:0] pat = 5'b01101;
    int b = 0;
    int k = 0;
    logic w, r;
    while (b < 8) begin
      case (mode)
        1:       w = pat[k % 5];
        2:       w = ($urandom_range(0, 2) != 0);
        default: w = 1'b1;
      endcase
      r = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
      if (w) begin
        if (b == 7) last_in_edge = edge_n;
        if (mode == 2)
          step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), r);
        else
          step(1'b1, 16'(base + 4*b), 16'(base + 4*b + 1), 16'(base + 4*b + 2),
               16'(base + 4*b + 3), r);
        b++;
      end else begin
        step(1'b0, '0, '0, '0, '0, r);
      end
      k++;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int i = 0;
    while ((exp_q.size() != 0) && (i < max_cycles)) begin
      idle(1'b1);
      i++;
    end
    check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_outs", 32'(out0 | out1 | out2 | out3), 32'd0);
    exp_q.delete();
    done_q.delete();
    pcnt = 0; rd_b = 0; ovf_m = 1'b0;
    edge_n += 2;
    rst = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int idx, input int w0, input int w1,
                            input int w2, input int w3);
    beat_t bt = '{data: '0, last: 1'b0, en: 0};
    if (idx < log_q.size()) bt = log_q[idx];
    check_val({tag, "_l0"}, 32'(bt.data[0*W +: W]), 32'(w0));
    check_val({tag, "_l1"}, 32'(bt.data[1*W +: W]), 32'(w1));
    check_val({tag, "_l2"}, 32'(bt.data[2*W +: W]), 32'(w2));
    check_val({tag, "_l3"}, 32'(bt.data[3*W +: W]), 32'(w3));
  endtask

  function automatic int log_en(input int idx);
    return (idx < log_q.size()) ? log_q[idx].en : -1000;
  endfunction

  initial begin
    int s;
    rst = 1'b1; wr_en = 1'b0; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    edge_n = 0; pcnt = 0; rd_b = 0; ovf_m = 1'b0; last_in_edge = 0;
    @(negedge clk);
    do_reset();

    // single frame 0..31
    s = log_q.size();
    send_frame(0, 0, 1);
    wait_drain(40);
    check_val("t1_count", 32'(log_q.size() - s), 32'd8);
    check_beat("t1_b0", s, 0, 16, 8, 24);
    check_beat("t1_b1", s + 1, 4, 20, 12, 28);
    check_beat("t1_b7", s + 7, 7, 23, 15, 31);
    check_val("t1_last", 32'((s + 7 < log_q.size()) ? log_q[s + 7].last : 1'b0), 32'd1);
    check_val("t1_latency", 32'(log_en(s)), 32'(last_in_edge + 2));

    // back-to-back frames
    s = log_q.size();
    send_frame(0, 0, 1);
    send_frame(100, 0, 1);
    wait_drain(40);
    check_val("t2_count", 32'(log_q.size() - s), 32'd16);
    check_val("t2_no_gap", 32'(log_en(s + 15) - log_en(s)), 32'd15);
    check_beat("t2_f2b0", s + 8, 100, 116, 108, 124);

    // sink stall at beat 2
    s = log_q.size();
    send_frame(200, 0, 1);
    for (int i = 0; (i < 20) && (log_q.size() - s < 2); i++) idle(1'b1);
    repeat (3) idle(1'b0);
    wait_drain(40);
    check_val("t3_count", 32'(log_q.size() - s), 32'd8);
    check_val("t3_stall_len", 32'(log_en(s + 2) - log_en(s + 1)), 32'd4);
    check_beat("t3_b2", s + 2, 202, 218, 210, 226);

    // overflow with sink blocked
    s = log_q.size();
    send_frame(300, 0, 0);
    send_frame(400, 0, 0);
    send_frame(500, 0, 0);
    check_val("t4_overflow", 32'(overflow), 32'd1);
    wait_drain(60);
    check_val("t4_count", 32'(log_q.size() - s), 32'd16);
    check_beat("t4_f1b0", s, 300, 316, 308, 324);
    check_beat("t4_f2b0", s + 8, 400, 416, 408, 424);
    do_reset();

    // wr_en gaps
    s = log_q.size();
    send_frame(0, 1, 1);
    wait_drain(40);
    check_val("t5_count", 32'(log_q.size() - s), 32'd8);
    check_beat("t5_b0", s, 0, 16, 8, 24);
    check_beat("t5_b7", s + 7, 7, 23, 15, 31);

    // reset discards a partial frame
    for (int b = 0; b < 5; b++)
      step(1'b1, 16'(600 + 4*b), 16'(601 + 4*b), 16'(602 + 4*b), 16'(603 + 4*b), 1'b1);
    do_reset();
    s = log_q.size();
    send_frame(700, 0, 1);
    wait_drain(40);
    check_val("t6_count", 32'(log_q.size() - s), 32'd8);
    check_beat("t6_b0", s, 700, 716, 708, 724);

    // randomized traffic
    for (int f = 0; f < 8; f++) begin
      send_frame(0, 2, 2);
      repeat ($urandom_range(0, 4)) idle(1'($urandom_range(0, 1)));
    end
    wait_drain(400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
